present_key_expand: RTL and testbench
=====================================

# present_key_expand

Forward PRESENT-128 key-schedule engine that sits directly upstream of the PRESENT decryption datapath. It accepts a 128-bit master key over a valid/ready handshake and iterates the forward key-register update once per clock for ROUNDS rounds. It then presents the final key-register state K32 (round key 32 in bits [127:64]), which is the starting state the decryption key schedule walks backwards from. One expansion is in flight at a time; the result is held until the consumer accepts it.

## Interface

- ROUNDS, 31, number of forward key-register updates; legal range 1..31.
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous, active-low reset.
- key  input  128  master key K1, sampled on accept.
- key_valid  input  1  master key present.
- key_ready  output  1  block idle and able to accept a key.
- dkey  output  128  final key-register state after ROUNDS updates.
- dkey_valid  output  1  dkey valid and held.
- dkey_ready  input  1  consumer accepts dkey.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - key_ready = 1.
  - On key_valid: load kreg <= key, rcnt <= 1, go to RUN.
- RUN, each cycle:
  - kreg <= update(kreg, rcnt).
  - If rcnt == ROUNDS, go to DONE; else rcnt <= rcnt + 1.
- update(K, i):
  - Rotate left by 61: T = {K[66:0], K[127:67]}.
  - T[127:124] = S(T[127:124]); T[123:120] = S(T[123:120]).
  - T[66:62] ^= i[4:0].
- S is the forward PRESENT S-box: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
- rcnt is a 5-bit register and never wraps; ROUNDS ≤ 31 guarantees this.
- DONE:
  - dkey_valid = 1; dkey = kreg, stable for the whole state.
  - When dkey_ready = 1, go to IDLE.
- key_ready is 0 in RUN and DONE. key_valid in those states is ignored; no queuing.
- Reset (rst_n = 0 on a rising edge), from any state:
  - State returns to IDLE; kreg and rcnt cleared to 0.
  - Any in-flight expansion is discarded, with no partial output.

## Timing

- Reset values: key_ready = 1, dkey_valid = 0, dkey = 128'h0.
- Accept at edge E0. RUN occupies edges E1..E_ROUNDS, then dkey_valid = 1 from after edge E_ROUNDS.
  - Accept-to-valid latency is ROUNDS+1 cycles (32 at the default).
- dkey_valid falls on the edge where dkey_ready = 1 is sampled in DONE. key_ready rises on the same edge.
- A new key can be accepted on the cycle after the handoff.
  - Minimum throughput: one key per ROUNDS+2 cycles.
- If dkey_ready is already high when DONE is entered, the output is valid for exactly one cycle.
- key_ready depends only on state and is combinational from registers. There is no combinational path from key_valid or dkey_ready to any output.
- Simultaneous rst_n = 0 with key_valid or dkey_ready: reset wins.

## Structure

- Shared package present_pkg holds:
  - PRESENT_SBOX constant, 16×4-bit.
  - PRESENT_KEY_W = 128, PRESENT_ROUNDS = 31.
  - State enum type for IDLE/RUN/DONE.
- Sub-module present_sbox4 (4-bit forward S-box lookup), instantiated twice on the top two nibbles of the rotated key.
  - It is the forward counterpart of the decryption S-box.
- All remaining logic lives in one always block plus a combinational update function.

## Test plan

- ROUNDS = 1, key = 0, key_valid pulsed with dkey_ready = 1 → key_ready = 1 in IDLE, dkey_valid high exactly 2 cycles after accept, dkey = 128'hCC000000_00000000_40000000_00000000.
- ROUNDS = 31, key = 0 → dkey_valid 32 cycles after accept; dkey matches the golden model. Feeding dkey to the decryption path with ciphertext 64'h96db702a2e6900af yields plaintext 64'h0.
- ROUNDS = 31, key = 128'h0123456789ABCDEF_FEDCBA9876543210, dkey_ready held 0 for 10 cycles after valid → dkey stable and dkey_valid high throughout; handoff on dkey_ready; key_ready high the next cycle.
- key_valid held high continuously with dkey_ready = 1 → keys accepted only in IDLE, one expansion per 33 cycles, no key accepted during RUN or DONE.
- rst_n asserted at cycle 15 of RUN → next cycle IDLE, key_ready = 1, dkey_valid = 0, dkey = 0. A following key expands correctly with full 32-cycle latency.
- Random keys (≥200) back-to-back with random dkey_ready stalls → every dkey matches the reference model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/present_key_expand_pkg.sv
// Shared PRESENT constants and types: forward S-box, key width, round count
// and the key-expansion FSM state encoding.
package present_pkg;

    localparam int PRESENT_KEY_W  = 128;
    localparam int PRESENT_ROUNDS = 31;

    localparam logic [3:0] PRESENT_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/present_key_expand_if.sv
// Key-in / expanded-key-out handshake bundle between the key loader,
// the expansion engine and the decryption datapath.
interface present_key_expand_if;
    import present_pkg::*;

    logic [PRESENT_KEY_W-1:0] key;
    logic                     key_valid;
    logic                     key_ready;
    logic [PRESENT_KEY_W-1:0] dkey;
    logic                     dkey_valid;
    logic                     dkey_ready;

    modport master (
        output key, key_valid, dkey_ready,
        input  key_ready, dkey, dkey_valid
    );

    modport slave (
        input  key, key_valid, dkey_ready,
        output key_ready, dkey, dkey_valid
    );

endinterface

// File: rtl/present_key_expand_sbox4.sv
// Forward PRESENT 4-bit S-box lookup (inverse of the decryption S-box).
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] value,
    output logic [3:0] subst
);

    assign subst = PRESENT_SBOX[value];

endmodule

// File: rtl/present_key_expand.sv
// Forward PRESENT-128 key schedule: iterates the key-register update ROUNDS
// times and holds the final state for the backward-walking decrypt schedule.
module present_key_expand
    import present_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    present_key_expand_if.slave  bus
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_t                   state_reg, state_next;
    logic [PRESENT_KEY_W-1:0] kreg_reg, kreg_next;
    logic [4:0]               rcnt_reg, rcnt_next;

    logic [PRESENT_KEY_W-1:0] rot;
    logic [7:0]               top_sub;
    logic [PRESENT_KEY_W-1:0] upd;

    assign rot = {kreg_reg[66:0], kreg_reg[127:67]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sbox
            present_sbox4 u_sbox (
                .value (rot[127-4*gi -: 4]),
                .subst (top_sub[7-4*gi -: 4])
            );
        end
    endgenerate

    // Splice the substituted nibbles back and fold in the round counter.
    function automatic logic [PRESENT_KEY_W-1:0] finish_round(
        input logic [PRESENT_KEY_W-1:0] t,
        input logic [7:0]               s,
        input logic [4:0]               i
    );
        logic [PRESENT_KEY_W-1:0] r;
        r          = t;
        r[127:120] = s;
        r[66:62]   = r[66:62] ^ i;
        return r;
    endfunction

    assign upd = finish_round(rot, top_sub, rcnt_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            kreg_reg  <= '0;
            rcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            kreg_reg  <= kreg_next;
            rcnt_reg  <= rcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        kreg_next  = kreg_reg;
        rcnt_next  = rcnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.key_valid) begin
                    kreg_next  = bus.key;
                    rcnt_next  = 5'd1;
                    state_next = RUN;
                end
            end
            RUN: begin
                kreg_next = upd;
                if (rcnt_reg == LAST_ROUND) begin
                    state_next = DONE;
                end else begin
                    rcnt_next = rcnt_reg + 5'd1;
                end
            end
            DONE: begin
                if (bus.dkey_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; no input-to-output paths.
    assign bus.key_ready  = (state_reg == IDLE);
    assign bus.dkey_valid = (state_reg == DONE);
    assign bus.dkey       = kreg_reg;

endmodule

// File: tb/tb_present_key_expand.sv
// Directed + random bench for present_key_expand with a reference key
// schedule, an in-order scoreboard and a backward decrypt of a known vector.
module tb_present_key_expand;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    present_key_expand_if bus31();
    present_key_expand_if bus1();

    present_key_expand #(.ROUNDS(31)) dut31 (.clk(clk), .rst_n(rst_n), .bus(bus31));
    present_key_expand #(.ROUNDS(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] y);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (sbox(4'(v)) == y) r = 4'(v);
        end
        return r;
    endfunction

    function automatic logic [127:0] fwd_update(input logic [127:0] k, input logic [4:0] i);
        logic [127:0] t;
        t          = {k[66:0], k[127:67]};
        t[127:124] = sbox(t[127:124]);
        t[123:120] = sbox(t[123:120]);
        t[66:62]   = t[66:62] ^ i;
        return t;
    endfunction

    function automatic logic [127:0] inv_update(input logic [127:0] k, input logic [4:0] i);
        logic [127:0] t;
        t          = k;
        t[66:62]   = t[66:62] ^ i;
        t[127:124] = inv_sbox(t[127:124]);
        t[123:120] = inv_sbox(t[123:120]);
        return {t[60:0], t[127:61]};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k0, input int rounds);
        logic [127:0] k;
        k = k0;
        for (int i = 1; i <= rounds; i++) k = fwd_update(k, 5'(i));
        return k;
    endfunction

    // Decrypt one block walking the key schedule backwards from K32.
    function automatic logic [63:0] decrypt(input logic [127:0] k32, input logic [63:0] c);
        logic [127:0] k;
        logic [63:0]  s, p;
        int           pj;
        k = k32;
        s = c ^ k[127:64];
        for (int i = 31; i >= 1; i--) begin
            k = inv_update(k, 5'(i));
            for (int j = 0; j < 64; j++) begin
                pj   = (j == 63) ? 63 : (j * 16) % 63;
                p[j] = s[pj];
            end
            for (int n = 0; n < 16; n++) s[4*n +: 4] = inv_sbox(p[4*n +: 4]);
            s = s ^ k[127:64];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard / protocol monitor for the ROUNDS=31 instance.
    logic [127:0] exp_q[$];
    logic [127:0] held;
    logic [127:0] exp_k;
    bit           busy = 0, cnting = 0, stall = 0;
    int           lat = 0, n_acc = 0, n_out = 0, n_disc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_disc += exp_q.size();
            exp_q.delete();
            busy   = 0;
            cnting = 0;
            stall  = 0;
        end else begin
            check("key_ready", 128'(bus31.key_ready), 128'(!busy));
            if (!busy) check("idle_valid", 128'(bus31.dkey_valid), 128'd0);
            if (cnting) begin
                lat++;
                if (bus31.dkey_valid === 1'b1) begin
                    check("latency", 128'(lat), 128'd32);
                    cnting = 0;
                end
            end
            if (stall) begin
                check("hold_valid", 128'(bus31.dkey_valid), 128'd1);
                check("hold_dkey", bus31.dkey, held);
            end
            if (bus31.dkey_valid && bus31.dkey_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 128'd1, 128'd0);
                end else begin
                    exp_k = exp_q.pop_front();
                    check("dkey", bus31.dkey, exp_k);
                end
                n_out++;
                busy = 0;
                $display("xfer %0d dkey=%h", n_out, bus31.dkey);
            end
            if (bus31.key_valid && bus31.key_ready) begin
                exp_q.push_back(expand(bus31.key, 31));
                n_acc++;
                busy   = 1;
                cnting = 1;
                lat    = 0;
            end
            stall = bus31.dkey_valid && !bus31.dkey_ready;
            held  = bus31.dkey;
        end
    end

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (bus31.dkey_valid !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 128'(bus31.dkey_valid), 128'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((bus31.key_ready !== 1'b1 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 128'(bus31.key_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] cap;
        int acc0, nk, cyc;
        bit acc;

        bus31.key = '0; bus31.key_valid = 0; bus31.dkey_ready = 0;
        bus1.key  = '0; bus1.key_valid  = 0; bus1.dkey_ready  = 1;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("rst_key_ready", 128'(bus31.key_ready), 128'd1);
        check("rst_dkey_valid", 128'(bus31.dkey_valid), 128'd0);
        check("rst_dkey", bus31.dkey, 128'd0);
        check("rst1_key_ready", 128'(bus1.key_ready), 128'd1);

        // ROUNDS=1, key 0, consumer always ready
        bus1.key_valid = 1;
        @(posedge clk); #1 bus1.key_valid = 0;
        check("r1_run_valid", 128'(bus1.dkey_valid), 128'd0);
        check("r1_run_ready", 128'(bus1.key_ready), 128'd0);
        @(posedge clk); #1;
        check("r1_valid", 128'(bus1.dkey_valid), 128'd1);
        check("r1_dkey", bus1.dkey, 128'hCC000000_00000000_40000000_00000000);
        @(posedge clk); #1;
        check("r1_handoff", 128'(bus1.dkey_valid), 128'd0);
        check("r1_ready_back", 128'(bus1.key_ready), 128'd1);

        // ROUNDS=31, key 0: known-answer decrypt through the backward schedule
        bus31.key = '0; bus31.key_valid = 1;
        @(posedge clk); #1 bus31.key_valid = 0;
        wait_valid("kz_wait", 40);
        cap = bus31.dkey;
        check("kz_dkey_model", cap, expand(128'd0, 31));
        check("kz_decrypt", 128'(decrypt(cap, 64'h96db702a2e6900af)), 128'd0);
        bus31.dkey_ready = 1;
        @(posedge clk); #1 bus31.dkey_ready = 0;

        // Held output under a 10-cycle stall, then handoff
        bus31.key = 128'h0123456789ABCDEF_FEDCBA9876543210; bus31.key_valid = 1;
        @(posedge clk); #1 bus31.key_valid = 0;
        wait_valid("st_wait", 40);
        repeat (10) begin @(posedge clk); #1; end
        check("st_still_valid", 128'(bus31.dkey_valid), 128'd1);
        bus31.dkey_ready = 1;
        @(posedge clk); #1 bus31.dkey_ready = 0;
        check("st_handoff", 128'(bus31.dkey_valid), 128'd0);
        check("st_ready_next", 128'(bus31.key_ready), 128'd1);

        // key_valid held high: one acceptance per 33 cycles
        acc0 = n_acc;
        bus31.dkey_ready = 1;
        bus31.key = rand128(); bus31.key_valid = 1;
        repeat (99) begin
            @(posedge clk); #1 bus31.key = rand128();
        end
        bus31.key_valid = 0;
        check("hold_accepts", 128'(n_acc - acc0), 128'd3);
        wait_idle("hold_drain", 60);
        bus31.dkey_ready = 0;

        // Reset during RUN, then a full-latency expansion
        bus31.key = rand128(); bus31.key_valid = 1;
        @(posedge clk); #1 bus31.key_valid = 0;
        repeat (14) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        check("mr_key_ready", 128'(bus31.key_ready), 128'd1);
        check("mr_dkey_valid", 128'(bus31.dkey_valid), 128'd0);
        check("mr_dkey", bus31.dkey, 128'd0);
        bus31.key = rand128(); bus31.key_valid = 1; bus31.dkey_ready = 1;
        @(posedge clk); #1 bus31.key_valid = 0;
        wait_idle("mr_drain", 60);

        // 200 random keys back-to-back with random consumer stalls
        nk = 0; cyc = 0;
        bus31.key = rand128(); bus31.key_valid = 1;
        while (nk < 200 && cyc < 20000) begin
            @(negedge clk);
            acc = bus31.key_valid && bus31.key_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                nk++;
                bus31.key = rand128();
                if (nk == 200) bus31.key_valid = 0;
            end
            bus31.dkey_ready = ($urandom_range(0, 3) != 0);
        end
        bus31.key_valid = 0;
        check("rnd_accepted", 128'(nk), 128'd200);
        bus31.dkey_ready = 1;
        wait_idle("rnd_drain", 100);
        check("sb_empty", 128'(exp_q.size()), 128'd0);
        check("sb_count", 128'(n_out), 128'(n_acc - n_disc));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
